// File: rtl/gyruss_sndcmd_mbox_pkg.sv
// Shared defaults and IRQ state encoding for the Gyruss main-to-sound command mailbox.
package gyruss_sndcmd_mbox_pkg;

    localparam int DEPTH_LOG2_DEF = 2;
    localparam int GAP_DEF        = 16;
    localparam int GAP_CNT_W      = 8;

    typedef enum logic [1:0] {
        IRQ_IDLE   = 2'd0,
        IRQ_ASSERT = 2'd1,
        IRQ_GAP    = 2'd2
    } irq_state_t;

endpackage

// File: rtl/gyruss_sync_fifo.sv
// Single-clock FIFO with drop-on-full; a push into a full FIFO is accepted only alongside a pop.
module gyruss_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  MCLK,
    input  logic                  RESET,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      head,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  pop_ok;
    logic                  push_ok;

    assign full    = (count == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr];

    // NOTE: storage has no reset; count gates every read, so stale contents are never observed.
    always_ff @(posedge MCLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/gyruss_sndcmd_mbox.sv
// Main-to-sound command mailbox: edge-detected posts into a FIFO, sticky overflow,
// and a sound-CPU interrupt with a guaranteed low gap after every serviced command.
module gyruss_sndcmd_mbox
    import gyruss_sndcmd_mbox_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int GAP        = GAP_DEF
) (
    input  logic                  MCLK,
    input  logic                  RESET,
    input  logic                  REQ,
    input  logic [7:0]            CMD,
    input  logic                  SRD,
    output logic [7:0]            SCMD,
    output logic                  SIRQ,
    output logic [DEPTH_LOG2:0]   COUNT,
    output logic                  OVF
);

    logic                 req_q;
    logic                 srd_q;
    logic                 push;
    logic                 pop;
    logic                 pop_ok;
    logic                 full;
    logic                 empty;
    logic [7:0]           head;
    logic [7:0]           last_q;
    irq_state_t           state_q;
    irq_state_t           state_d;
    logic [GAP_CNT_W-1:0] gap_q;
    logic [GAP_CNT_W-1:0] gap_d;

    assign push   = REQ && !req_q;
    assign pop    = !SRD && srd_q;
    assign pop_ok = pop && !empty;

    gyruss_sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .MCLK  (MCLK),
        .RESET (RESET),
        .push  (push),
        .pop   (pop),
        .din   (CMD),
        .head  (head),
        .count (COUNT),
        .full  (full),
        .empty (empty)
    );

    // Once drained, the sound CPU keeps seeing the command it last consumed.
    assign SCMD = empty ? last_q : head;
    assign SIRQ = (state_q == IRQ_ASSERT);

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            req_q   <= 1'b0;
            srd_q   <= 1'b0;
            last_q  <= '0;
            OVF     <= 1'b0;
            state_q <= IRQ_IDLE;
            gap_q   <= '0;
        end else begin
            req_q   <= REQ;
            srd_q   <= SRD;
            state_q <= state_d;
            gap_q   <= gap_d;
            if (pop_ok) begin
                last_q <= head;
            end
            if (push && full && !pop_ok) begin
                OVF <= 1'b1;
            end
        end
    end

    // NOTE: defaults first so every path assigns state_d/gap_d and no latch is inferred.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        unique case (state_q)
            IRQ_IDLE: begin
                if (!empty) begin
                    state_d = IRQ_ASSERT;
                end
            end
            IRQ_ASSERT: begin
                if (pop) begin
                    gap_d   = GAP_CNT_W'(GAP - 1);
                    state_d = IRQ_GAP;
                end
            end
            IRQ_GAP: begin
                if (gap_q == '0) begin
                    state_d = empty ? IRQ_IDLE : IRQ_ASSERT;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = IRQ_IDLE;
        endcase
    end

endmodule
